// File: rtl/fifo_sync_param_if.sv
// Handshake and status bundle for fifo_sync_param.
// master: producer/consumer side; slave: the FIFO itself.
interface fifo_sync_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              wen;
  logic [DATA_W-1:0] din;
  logic              ren;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wen, din, ren,
    input  dout, dout_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wen, din, ren,
    output dout, dout_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty flags and
// registered overflow/underflow error pulses. DEPTH need not be a power of two.
// Optional macro FIFO_SYNC_FWFT_EN selects first-word-fall-through read data;
// when undefined, reads have one cycle of latency with a dout_valid strobe.
module fifo_sync_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input logic               clock,
  input logic               rst,
  fifo_sync_param_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_full;
  logic              w_empty;
  logic              w_rd_ok;
  logic              w_wr_ok;
  logic [PTR_W-1:0]  w_wptr_nxt;
  logic [PTR_W-1:0]  w_rptr_nxt;

  assign w_full  = (32'(r_count) == DEPTH);
  assign w_empty = (r_count == '0);
  assign w_rd_ok = bus.ren & ~w_empty;
  // A write into a full FIFO only fits if a read frees a slot at the same edge.
  assign w_wr_ok = bus.wen & (~w_full | w_rd_ok);

  // Explicit wrap so non power-of-two depths never index past the last entry.
  assign w_wptr_nxt = (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
  assign w_rptr_nxt = (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);

  // Pointers, occupancy and error pulses.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wptr <= w_wptr_nxt;
      if (w_rd_ok) r_rptr <= w_rptr_nxt;
      if (w_wr_ok && !w_rd_ok) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_rd_ok && !w_wr_ok) begin
        r_count <= r_count - CNT_W'(1);
      end
      r_overflow  <= bus.wen & ~w_wr_ok;
      r_underflow <= bus.ren & w_empty;
    end
  end

  // Storage array; contents survive reset, but reset blocks a same-cycle write.
  always_ff @(posedge clock) begin
    if (!rst && w_wr_ok) r_mem[r_wptr] <= bus.din;
  end

`ifdef FIFO_SYNC_FWFT_EN
  // Head entry is always presented; ren only pops it.
  assign bus.dout       = r_mem[r_rptr];
  assign bus.dout_valid = ~w_empty;
`else
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;

  // Registered read: dout loads on an accepted read and holds otherwise.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= w_rd_ok;
      if (w_rd_ok) r_dout <= r_mem[r_rptr];
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
`endif

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (32'(r_count) >= AF_LEVEL);
  assign bus.almost_empty = (32'(r_count) <= AE_LEVEL);
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: a DEPTH=4 instance (a) and a DEPTH=5
// instance (b) for wrap-around; expected read data flows through scoreboard queues.
module tb_fifo_sync_param;
  logic clock = 1'b0;
  logic rst   = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  logic [7:0] q_a [$];
  logic [7:0] q_b [$];

  fifo_sync_param_if #(.DATA_W(8), .DEPTH(4)) a_bus ();
  fifo_sync_param_if #(.DATA_W(8), .DEPTH(5)) b_bus ();

  fifo_sync_param #(.DATA_W(8), .DEPTH(4), .AF_LEVEL(2), .AE_LEVEL(2)) u_dut_a (
    .clock (clock),
    .rst   (rst),
    .bus   (a_bus)
  );

  fifo_sync_param #(.DATA_W(8), .DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(2)) u_dut_b (
    .clock (clock),
    .rst   (rst),
    .bus   (b_bus)
  );

  always #5 clock = ~clock;

  // Drive one cycle on instance a, then sample 1 time unit after the edge.
  task automatic tick_a(input logic w, input logic [7:0] d, input logic r);
    a_bus.wen = w;
    a_bus.din = d;
    a_bus.ren = r;
    @(posedge clock);
    #1;
    a_bus.wen = 1'b0;
    a_bus.ren = 1'b0;
  endtask

  task automatic tick_b(input logic w, input logic [7:0] d, input logic r);
    b_bus.wen = w;
    b_bus.din = d;
    b_bus.ren = r;
    @(posedge clock);
    #1;
    b_bus.wen = 1'b0;
    b_bus.ren = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clock);
    #1;
    rst = 1'b0;
    q_a.delete();
    q_b.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (a_bus.count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", a_bus.count); end
    checks++; if (a_bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", a_bus.empty); end
    checks++; if (a_bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", a_bus.full); end
    checks++; if (a_bus.almost_empty !== 1'b1) begin failures++; $display("FAIL reset_ae got=%b exp=1", a_bus.almost_empty); end
    checks++; if (a_bus.almost_full !== 1'b0) begin failures++; $display("FAIL reset_af got=%b exp=0", a_bus.almost_full); end
    checks++; if (a_bus.dout_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", a_bus.dout_valid); end
    checks++; if (a_bus.overflow !== 1'b0 || a_bus.underflow !== 1'b0) begin failures++; $display("FAIL reset_err got=%b%b exp=00", a_bus.overflow, a_bus.underflow); end
`ifndef FIFO_SYNC_FWFT_EN
    checks++; if (a_bus.dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", a_bus.dout); end
`endif
    checks++; if (b_bus.count !== 3'd0 || b_bus.empty !== 1'b1) begin failures++; $display("FAIL reset_b got=%0d/%b exp=0/1", b_bus.count, b_bus.empty); end
  endtask

  task automatic test_fill();
    logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      tick_a(1'b1, d[i], 1'b0);
      q_a.push_back(d[i]);
      checks++; if (a_bus.count !== 3'(i + 1)) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", a_bus.count, i + 1); end
      checks++; if (a_bus.almost_full !== (i >= 1)) begin failures++; $display("FAIL fill_af got=%b exp=%b", a_bus.almost_full, (i >= 1)); end
      checks++; if (a_bus.full !== (i == 3)) begin failures++; $display("FAIL fill_full got=%b exp=%b", a_bus.full, (i == 3)); end
    end
    tick_a(1'b1, 8'h55, 1'b0);
    checks++; if (a_bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%b exp=1", a_bus.overflow); end
    checks++; if (a_bus.count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", a_bus.count); end
    tick_a(1'b0, 8'h00, 1'b0);
    checks++; if (a_bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", a_bus.overflow); end
  endtask

  task automatic test_drain();
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) begin
      tick_a(1'b0, 8'h00, 1'b1);
      exp = (q_a.size() > 0) ? q_a.pop_front() : 8'hxx;
      checks++; if (a_bus.dout_valid !== 1'b1) begin failures++; $display("FAIL drain_valid got=%b exp=1", a_bus.dout_valid); end
      checks++; if (a_bus.dout !== exp) begin failures++; $display("FAIL drain_dout got=%h exp=%h", a_bus.dout, exp); end
      checks++; if (a_bus.count !== 3'(3 - i)) begin failures++; $display("FAIL drain_count got=%0d exp=%0d", a_bus.count, 3 - i); end
      checks++; if (a_bus.empty !== (i == 3)) begin failures++; $display("FAIL drain_empty got=%b exp=%b", a_bus.empty, (i == 3)); end
      checks++; if (a_bus.almost_empty !== (i >= 1)) begin failures++; $display("FAIL drain_ae got=%b exp=%b", a_bus.almost_empty, (i >= 1)); end
    end
    tick_a(1'b0, 8'h00, 1'b1);
    checks++; if (a_bus.underflow !== 1'b1) begin failures++; $display("FAIL udf_pulse got=%b exp=1", a_bus.underflow); end
    checks++; if (a_bus.dout_valid !== 1'b0) begin failures++; $display("FAIL udf_valid got=%b exp=0", a_bus.dout_valid); end
    checks++; if (a_bus.dout !== 8'h44) begin failures++; $display("FAIL udf_hold got=%h exp=44", a_bus.dout); end
    checks++; if (a_bus.count !== 3'd0) begin failures++; $display("FAIL udf_count got=%0d exp=0", a_bus.count); end
    tick_a(1'b0, 8'h00, 1'b0);
    checks++; if (a_bus.underflow !== 1'b0) begin failures++; $display("FAIL udf_clear got=%b exp=0", a_bus.underflow); end
  endtask

  // DEPTH=5: pointers must cross 4 -> 0 without losing or repeating a word.
  task automatic test_wrap();
    logic [7:0] exp;
    int n_wr [2] = '{3, 5};
    logic [7:0] base = 8'hA0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < n_wr[pass]; i++) begin
        tick_b(1'b1, base, 1'b0);
        q_b.push_back(base);
        base = base + 8'd1;
      end
      if (pass == 1) begin
        checks++; if (b_bus.full !== 1'b1 || b_bus.count !== 3'd5) begin failures++; $display("FAIL wrap_full got=%b/%0d exp=1/5", b_bus.full, b_bus.count); end
      end
      for (int i = 0; i < n_wr[pass]; i++) begin
        tick_b(1'b0, 8'h00, 1'b1);
        exp = (q_b.size() > 0) ? q_b.pop_front() : 8'hxx;
        checks++; if (b_bus.dout_valid !== 1'b1 || b_bus.dout !== exp) begin failures++; $display("FAIL wrap_dout got=%h/%b exp=%h/1", b_bus.dout, b_bus.dout_valid, exp); end
      end
      checks++; if (b_bus.empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%b exp=1", b_bus.empty); end
    end
  endtask

  task automatic test_simul();
    logic [7:0] exp;
    // Mid-level: count unchanged, order kept.
    tick_a(1'b1, 8'h01, 1'b0); q_a.push_back(8'h01);
    tick_a(1'b1, 8'h02, 1'b0); q_a.push_back(8'h02);
    tick_a(1'b1, 8'h03, 1'b1); q_a.push_back(8'h03);
    exp = q_a.pop_front();
    checks++; if (a_bus.count !== 3'd2) begin failures++; $display("FAIL simul_mid_count got=%0d exp=2", a_bus.count); end
    checks++; if (a_bus.dout !== exp || a_bus.dout_valid !== 1'b1) begin failures++; $display("FAIL simul_mid_dout got=%h exp=%h", a_bus.dout, exp); end
    // Fill up, then simultaneous on full.
    tick_a(1'b1, 8'h04, 1'b0); q_a.push_back(8'h04);
    tick_a(1'b1, 8'h05, 1'b0); q_a.push_back(8'h05);
    checks++; if (a_bus.full !== 1'b1) begin failures++; $display("FAIL simul_pre_full got=%b exp=1", a_bus.full); end
    tick_a(1'b1, 8'hAA, 1'b1); q_a.push_back(8'hAA);
    exp = q_a.pop_front();
    checks++; if (a_bus.count !== 3'd4 || a_bus.full !== 1'b1) begin failures++; $display("FAIL simul_full_count got=%0d/%b exp=4/1", a_bus.count, a_bus.full); end
    checks++; if (a_bus.overflow !== 1'b0) begin failures++; $display("FAIL simul_full_ovf got=%b exp=0", a_bus.overflow); end
    checks++; if (a_bus.dout !== exp) begin failures++; $display("FAIL simul_full_dout got=%h exp=%h", a_bus.dout, exp); end
    for (int i = 0; i < 4; i++) begin
      tick_a(1'b0, 8'h00, 1'b1);
      exp = (q_a.size() > 0) ? q_a.pop_front() : 8'hxx;
      checks++; if (a_bus.dout !== exp || a_bus.dout_valid !== 1'b1) begin failures++; $display("FAIL simul_drain got=%h exp=%h", a_bus.dout, exp); end
    end
    checks++; if (a_bus.dout !== 8'hAA) begin failures++; $display("FAIL simul_aa_last got=%h exp=aa", a_bus.dout); end
    // Empty: write wins, read rejected.
    tick_a(1'b1, 8'h3C, 1'b1); q_a.push_back(8'h3C);
    checks++; if (a_bus.count !== 3'd1) begin failures++; $display("FAIL simul_empty_count got=%0d exp=1", a_bus.count); end
    checks++; if (a_bus.underflow !== 1'b1 || a_bus.dout_valid !== 1'b0) begin failures++; $display("FAIL simul_empty_udf got=%b/%b exp=1/0", a_bus.underflow, a_bus.dout_valid); end
    tick_a(1'b0, 8'h00, 1'b1);
    exp = q_a.pop_front();
    checks++; if (a_bus.dout !== exp || a_bus.empty !== 1'b1) begin failures++; $display("FAIL simul_empty_dout got=%h/%b exp=%h/1", a_bus.dout, a_bus.empty, exp); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) tick_a(1'b1, 8'(8'hC0 + i), 1'b0);
    checks++; if (a_bus.count !== 3'd3) begin failures++; $display("FAIL mrst_pre got=%0d exp=3", a_bus.count); end
    // wen/ren during reset must be ignored.
    rst = 1'b1;
    a_bus.wen = 1'b1;
    a_bus.ren = 1'b1;
    a_bus.din = 8'h99;
    @(posedge clock);
    #1;
    rst = 1'b0;
    a_bus.wen = 1'b0;
    a_bus.ren = 1'b0;
    q_a.delete();
    checks++; if (a_bus.count !== 3'd0 || a_bus.empty !== 1'b1) begin failures++; $display("FAIL mrst_count got=%0d/%b exp=0/1", a_bus.count, a_bus.empty); end
    checks++; if (a_bus.dout !== 8'h00 || a_bus.dout_valid !== 1'b0) begin failures++; $display("FAIL mrst_dout got=%h/%b exp=00/0", a_bus.dout, a_bus.dout_valid); end
    tick_a(1'b1, 8'h5A, 1'b0); q_a.push_back(8'h5A);
    tick_a(1'b0, 8'h00, 1'b1);
    checks++; if (a_bus.dout !== q_a.pop_front() || a_bus.dout_valid !== 1'b1) begin failures++; $display("FAIL mrst_after got=%h exp=5a", a_bus.dout); end
  endtask

  task automatic test_fwft();
    do_reset();
    tick_a(1'b1, 8'h77, 1'b0);
    checks++; if (a_bus.dout_valid !== 1'b1) begin failures++; $display("FAIL fwft_valid got=%b exp=1", a_bus.dout_valid); end
    checks++; if (a_bus.dout !== 8'h77) begin failures++; $display("FAIL fwft_dout got=%h exp=77", a_bus.dout); end
    checks++; if (a_bus.count !== 3'd1) begin failures++; $display("FAIL fwft_count got=%0d exp=1", a_bus.count); end
    tick_a(1'b1, 8'h78, 1'b0);
    checks++; if (a_bus.dout !== 8'h77) begin failures++; $display("FAIL fwft_head got=%h exp=77", a_bus.dout); end
    tick_a(1'b0, 8'h00, 1'b1);
    checks++; if (a_bus.dout !== 8'h78 || a_bus.dout_valid !== 1'b1) begin failures++; $display("FAIL fwft_next got=%h exp=78", a_bus.dout); end
    tick_a(1'b0, 8'h00, 1'b1);
    checks++; if (a_bus.dout_valid !== 1'b0 || a_bus.empty !== 1'b1) begin failures++; $display("FAIL fwft_pop got=%b/%b exp=0/1", a_bus.dout_valid, a_bus.empty); end
  endtask

  initial begin
    a_bus.wen = 1'b0; a_bus.ren = 1'b0; a_bus.din = 8'h00;
    b_bus.wen = 1'b0; b_bus.ren = 1'b0; b_bus.din = 8'h00;
    @(posedge clock);
    #1;
    test_reset();
`ifdef FIFO_SYNC_FWFT_EN
    test_fwft();
`else
    test_fill();
    test_drain();
    test_wrap();
    test_simul();
    test_mid_reset();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
